// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared phase state encoding, op bit positions and default durations
package wm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } phase_state_t;

    // op = {soak, wash, rinse, spin}
    localparam int OP_W     = 4;
    localparam int OP_SOAK  = 3;
    localparam int OP_WASH  = 2;
    localparam int OP_RINSE = 1;
    localparam int OP_SPIN  = 0;

    localparam int DEF_TICK_DIV  = 50_000_000;
    localparam int DEF_SOAK_SEC  = 300;
    localparam int DEF_WASH_SEC  = 600;
    localparam int DEF_RINSE_SEC = 300;
    localparam int DEF_SPIN_SEC  = 180;
    localparam int DEF_CNT_W     = 12;

    // Zero or exactly one operation bit set.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op & (op - 4'd1)) == 4'd0;
    endfunction

endpackage

// File: rtl/wm_tick_gen.sv
// rtl/wm_tick_gen.sv - TICK_DIV prescaler with clear and enable, one-cycle tick out
module wm_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] C_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == C_LAST);

endmodule

// File: rtl/wm_phase_timer.sv
// rtl/wm_phase_timer.sv - per-phase countdown timer with actuator outputs for the wash controller
// Optional LID_PAUSE_EN: lid open freezes timing and drops motor/drain while running.
module wm_phase_timer
    import wm_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int SOAK_SEC  = DEF_SOAK_SEC,
    parameter int WASH_SEC  = DEF_WASH_SEC,
    parameter int RINSE_SEC = DEF_RINSE_SEC,
    parameter int SPIN_SEC  = DEF_SPIN_SEC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             soak_Operation,
    input  logic             wash_Operation,
    input  logic             rinse_Operation,
    input  logic             spin_Operation,
    input  logic             lid,
    output logic             phase_Done,
    output logic [CNT_W-1:0] time_Remaining,
    output logic             motor_On,
    output logic             drain_Valve,
    output logic             busy,
    output logic             fault_Illegal
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    phase_state_t     r_state, w_nxt_state;
    logic [CNT_W-1:0] r_count, w_nxt_count;
    logic [OP_W-1:0]  r_op_q;
    logic             r_done, r_motor, r_drain, r_fault;
    logic             w_nxt_done, w_nxt_motor, w_nxt_drain;
    logic [OP_W-1:0]  w_op;
    logic             w_legal, w_active, w_load, w_pause, w_tick, w_tick_en, w_tick_clr;
    logic [CNT_W-1:0] w_dur;

    assign w_op     = {soak_Operation, wash_Operation, rinse_Operation, spin_Operation};
    assign w_legal  = op_legal(w_op);
    assign w_active = w_legal && (w_op != '0);
    assign w_load   = w_active && (w_op != r_op_q);

`ifdef LID_PAUSE_EN
    assign w_pause = lid;
`else
    logic w_unused_lid;
    assign w_unused_lid = lid;
    assign w_pause      = 1'b0;
`endif

    always_comb begin
        w_dur = CNT_W'(SOAK_SEC);
        if (w_op[OP_WASH])  w_dur = CNT_W'(WASH_SEC);
        if (w_op[OP_RINSE]) w_dur = CNT_W'(RINSE_SEC);
        if (w_op[OP_SPIN])  w_dur = CNT_W'(SPIN_SEC);
    end

    // Prescaler idles at zero outside RUN so every phase starts on a full tick period.
    assign w_tick_en  = (r_state == ST_RUN) && !w_pause;
    assign w_tick_clr = w_load || (r_state != ST_RUN);

    wm_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clr   (w_tick_clr),
        .i_en    (w_tick_en),
        .o_tick  (w_tick)
    );

    // Op change beats a coincident tick; illegal op behaves like op==0.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_count = r_count;
        w_nxt_done  = 1'b0;
        if (!w_active) begin
            w_nxt_state = ST_IDLE;
            w_nxt_count = '0;
        end else if (w_load) begin
            w_nxt_state = ST_RUN;
            w_nxt_count = w_dur;
        end else if (r_state == ST_RUN && !w_pause) begin
            if (r_count == '0) begin
                w_nxt_state = ST_DONE;
                w_nxt_done  = 1'b1;
            end else if (w_tick) begin
                w_nxt_count = r_count - C_ONE;
                if (r_count == C_ONE) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_done  = 1'b1;
                end
            end
        end
        // A zero-length phase never drives actuators.
        w_nxt_motor = (w_nxt_state == ST_RUN) && (w_nxt_count != '0) && !w_pause &&
                      (w_op[OP_WASH] || w_op[OP_RINSE] || w_op[OP_SPIN]);
        w_nxt_drain = (w_nxt_state == ST_RUN) && (w_nxt_count != '0) && !w_pause &&
                      w_op[OP_SPIN];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_op_q  <= '0;
            r_done  <= 1'b0;
            r_motor <= 1'b0;
            r_drain <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_count <= w_nxt_count;
            r_op_q  <= w_op;
            r_done  <= w_nxt_done;
            r_motor <= w_nxt_motor;
            r_drain <= w_nxt_drain;
            r_fault <= !w_legal;
        end
    end

    assign phase_Done     = r_done;
    assign time_Remaining = r_count;
    assign motor_On       = r_motor;
    assign drain_Valve    = r_drain;
    assign busy           = (r_state == ST_RUN);
    assign fault_Illegal  = r_fault;

endmodule

// File: tb/tb_wm_phase_timer.sv
// tb/tb_wm_phase_timer.sv - scoreboard bench for wm_phase_timer (TICK_DIV=4, durations 3/2/1/0)
module tb_wm_phase_timer;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       soak_Operation = 1'b0, wash_Operation = 1'b0;
    logic       rinse_Operation = 1'b0, spin_Operation = 1'b0;
    logic       lid = 1'b0;
    logic       phase_Done, motor_On, drain_Valve, busy, fault_Illegal;
    logic [3:0] time_Remaining;

`ifdef LID_PAUSE_EN
    localparam int LID_EXTRA = 10;
`else
    localparam int LID_EXTRA = 0;
`endif

    wm_phase_timer #(
        .TICK_DIV(4), .SOAK_SEC(3), .WASH_SEC(2), .RINSE_SEC(1), .SPIN_SEC(0), .CNT_W(4)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .soak_Operation  (soak_Operation),
        .wash_Operation  (wash_Operation),
        .rinse_Operation (rinse_Operation),
        .spin_Operation  (spin_Operation),
        .lid             (lid),
        .phase_Done      (phase_Done),
        .time_Remaining  (time_Remaining),
        .motor_On        (motor_On),
        .drain_Valve     (drain_Valve),
        .busy            (busy),
        .fault_Illegal   (fault_Illegal)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_out(input string tag, input int t, input int b, input int m, input int d);
        check({tag, ".time_Remaining"}, 32'(time_Remaining), t);
        check({tag, ".busy"}, 32'(busy), b);
        check({tag, ".motor_On"}, 32'(motor_On), m);
        check({tag, ".drain_Valve"}, 32'(drain_Valve), d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic s, input logic w, input logic r, input logic p);
        soak_Operation  = s;
        wash_Operation  = w;
        rinse_Operation = r;
        spin_Operation  = p;
    endtask

    // Monitor: every phase_Done pulse must match the next expected cycle.
    always @(negedge clock) begin
        if (reset_n && phase_Done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_phase_Done: got pulse at cycle %0d expected none", cyc);
            end else begin
                check("phase_Done_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int k;
        step(2);
        chk_out("reset", 0, 0, 0, 0);
        check("reset.phase_Done", 32'(phase_Done), 0);
        check("reset.fault_Illegal", 32'(fault_Illegal), 0);
        reset_n = 1'b1;
        step(2);

        // 1: soak 3 s
        k = cyc;
        set_op(1, 0, 0, 0);
        exp_q.push_back(k + 13);
        step(1);  chk_out("soak.t3", 3, 1, 0, 0);
        step(4);  chk_out("soak.t2", 2, 1, 0, 0);
        step(4);  chk_out("soak.t1", 1, 1, 0, 0);
        step(4);  chk_out("soak.done", 0, 0, 0, 0);
        step(10); chk_out("soak.held", 0, 0, 0, 0);
        set_op(0, 0, 0, 0);
        step(2);

        // 2: wash aborted by rinse after 5 cycles
        k = cyc;
        set_op(0, 1, 0, 0);
        step(1);  chk_out("wash.load", 2, 1, 1, 0);
        step(4);  chk_out("wash.t1", 1, 1, 1, 0);
        set_op(0, 0, 1, 0);
        exp_q.push_back(k + 10);
        step(1);  chk_out("rinse.load", 1, 1, 1, 0);
        step(3);  chk_out("rinse.mid", 1, 1, 1, 0);
        step(1);  chk_out("rinse.done", 0, 0, 0, 0);
        set_op(0, 0, 0, 0);
        step(3);

        // 3: zero-length spin
        k = cyc;
        set_op(0, 0, 0, 1);
        exp_q.push_back(k + 2);
        step(1);  chk_out("spin.load", 0, 1, 0, 0);
        step(1);  chk_out("spin.done", 0, 0, 0, 0);
        step(3);  chk_out("spin.held", 0, 0, 0, 0);
        set_op(0, 0, 0, 0);
        step(2);

        // 4: illegal op aborts a running wash
        set_op(0, 1, 0, 0);
        step(2);  chk_out("pre_illegal", 2, 1, 1, 0);
        set_op(0, 1, 1, 0);
        step(1);
        check("illegal.fault_Illegal", 32'(fault_Illegal), 1);
        chk_out("illegal", 0, 0, 0, 0);
        step(10);
        set_op(0, 0, 0, 0);
        step(1);
        check("illegal_clear.fault_Illegal", 32'(fault_Illegal), 0);
        step(2);

        // 5: async reset mid-wash
        set_op(0, 1, 0, 0);
        step(6);  chk_out("pre_reset", 1, 1, 1, 0);
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0, 0);
        check("async_reset.phase_Done", 32'(phase_Done), 0);
        set_op(0, 0, 0, 0);
        step(2);
        reset_n = 1'b1;
        step(15); chk_out("post_reset", 0, 0, 0, 0);

        // 6: lid open for 10 cycles during wash
        k = cyc;
        set_op(0, 1, 0, 0);
        exp_q.push_back(k + 9 + LID_EXTRA);
        step(3);
        lid = 1'b1;
        step(2);
        chk_out("lid.open", (LID_EXTRA != 0) ? 2 : 1, 1, (LID_EXTRA != 0) ? 0 : 1, 0);
        step(8);
        lid = 1'b0;
        step(10); chk_out("lid.end", 0, 0, 0, 0);
        set_op(0, 0, 0, 0);
        step(5);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
